uart_tx_scheduler: RTL and testbench

- Shares one byte serializer (async_transmitter) among N_REQ requesters. Each requester sends a packet of N_NUMS signed 16-bit nums.
- Arbitrates round-robin and captures the winner's payload.
- Frames the packet as a header byte followed by the num bytes, LSB first.
- Paces bytes on the serializer busy flag, so no byte is issued while the serializer is still shifting.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 33 +++
 rtl/uart_tx_scheduler.sv | 134 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// Holds the payload word type, the header tag and the FSM states.
package uart_pkg;

  typedef logic signed [15:0] num;

  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    WAIT,
    FINISH
  } sched_state_t;

  function automatic logic [7:0] num_byte(
    input num   n,
    input logic hi
  );
    return hi ? n[15:8] : n[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping.
// Purely combinational; the pointer register lives in the scheduler.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (en && !found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one byte serializer among N_REQ requesters, round-robin,
// sending a header byte then each num LSB first, paced on tx_busy.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int N_NUMS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  num               req_nums [N_REQ*N_NUMS],
  output logic [N_REQ-1:0] grant,
  output logic             done,
  output logic             sched_busy,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_byte
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NB = 1 + 2 * N_NUMS;
  localparam int BW = $clog2(NB);
  localparam logic [BW-1:0] LAST_B  = BW'(NB - 1);
  localparam logic [IW-1:0] LAST_ID = IW'(N_REQ - 1);

  sched_state_t state_q, state_d;

  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    id_q;
  logic [IW-1:0]    arb_idx;
  logic [IW-1:0]    nxt_ptr;
  logic [N_REQ-1:0] arb_gnt;
  logic [BW-1:0]    idx_q;
  num               buf_q [N_NUMS];
  logic [7:0]       cur_byte;
  logic             idle;
  logic             any_req;
  logic             cap;
  logic             last;
  int               k;

  assign idle    = (state_q == IDLE);
  assign any_req = |req;
  assign cap     = idle && any_req;
  assign last    = (idx_q == LAST_B);
  assign nxt_ptr = (arb_idx == LAST_ID) ? '0 : arb_idx + IW'(1);

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .req(req),
    .ptr(ptr_q),
    .en (idle),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  // Byte 0 is the header; byte k>0 is num (k-1)/2, low half first.
  always_comb begin
    k        = int'(idx_q);
    cur_byte = {HDR_TAG, 4'(id_q)};
    if (k != 0) begin
      cur_byte = num_byte(buf_q[(k-1)/2], ((k - 1) % 2) != 0);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = START;
      START:   state_d = GAP;
      GAP:     state_d = WAIT;
      WAIT:    if (!tx_busy) state_d = last ? FINISH : START;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      id_q       <= '0;
      idx_q      <= '0;
      grant      <= '0;
      done       <= 1'b0;
      sched_busy <= 1'b0;
      tx_start   <= 1'b0;
      tx_byte    <= 8'h00;
    end else begin
      grant    <= '0;
      done     <= 1'b0;
      tx_start <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            grant      <= arb_gnt;
            id_q       <= arb_idx;
            ptr_q      <= nxt_ptr;
            idx_q      <= '0;
            sched_busy <= 1'b1;
          end
        end
        START: begin
          tx_start <= 1'b1;
          tx_byte  <= cur_byte;
        end
        WAIT: begin
          if (!tx_busy) begin
            if (last) done  <= 1'b1;
            else      idx_q <= idx_q + BW'(1);
          end
        end
        FINISH:  sched_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // Payload contents are irrelevant until a capture, so no reset here.
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int n = 0; n < N_NUMS; n++) begin
        buf_q[n] <= req_nums[int'(arb_idx) * N_NUMS + n];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a busy-flag serializer model.
// N_REQ=4, N_NUMS=2: five bytes per packet.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  num         nums [8];
  logic [3:0] grant;
  logic       done;
  logic       sched_busy;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_byte;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int busy_cnt = 0;
  int hold = 10;
  logic busy_force = 1'b0;
  int start_cnt = 0;
  int grant_cnt = 0;
  int done_cnt = 0;
  int multi_err = 0;
  int done_cyc = 0;
  int fall_cyc = 0;
  logic [7:0] byte_q [$];
  int start_q [$];

  always #5 clk = ~clk;

  assign tx_busy = (busy_cnt != 0) || busy_force;

  uart_tx_scheduler #(
    .N_REQ (4),
    .N_NUMS(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_nums  (nums),
    .grant     (grant),
    .done      (done),
    .sched_busy(sched_busy),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_byte   (tx_byte)
  );

  // Monitor plus serializer model: busy for `hold` cycles per byte.
  always @(negedge clk) begin
    cyc++;
    if (tx_start) begin
      byte_q.push_back(tx_byte);
      start_q.push_back(cyc);
      start_cnt++;
    end
    if (grant != 4'b0) begin
      grant_cnt++;
      if ($countones(grant) != 1) multi_err++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tx_start) busy_cnt = hold;
    else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) fall_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    byte_q.delete();
    start_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 4'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    clear_q();
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] eg,
                            output logic [3:0] g);
    int n;
    n = 0;
    g = 4'b0;
    while (g == 4'b0 && n < 300) begin
      tick();
      g = grant;
      n++;
    end
    check({tag, "_grant"}, g, eg);
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_done"}, done_cnt - d0, 1);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input logic [7:0] e4);
    logic [7:0] e [5];
    e = '{e0, e1, e2, e3, e4};
    check({tag, "_nbytes"}, byte_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < byte_q.size())
        check($sformatf("%s_b%0d", tag, i), byte_q[i], e[i]);
    end
  endtask

  task automatic check_pkt(input string tag, input int id);
    check_bytes(tag, {4'hA, 4'(id)},
                nums[2*id][7:0], nums[2*id][15:8],
                nums[2*id+1][7:0], nums[2*id+1][15:8]);
  endtask

  task automatic run_pkt(input string tag, input logic [3:0] r,
                         input int id);
    logic [3:0] g;
    int d0;
    clear_q();
    d0  = done_cnt;
    req = r;
    wait_grant(tag, 4'b0001 << id, g);
    req = 4'b0;
    wait_done(tag, d0);
    check_pkt(tag, id);
  endtask

  initial begin
    logic [3:0] g;
    int s0, d0, g0, c0, rel, n;

    reset      = 1'b0;
    req        = 4'b0;
    for (int i = 0; i < 8; i++) nums[i] = '0;
    repeat (3) tick();
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", sched_busy, 0);
    check("rst_start", tx_start, 0);
    check("rst_byte", tx_byte, 0);
    reset = 1'b1;
    tick();

    // Single requester, full packet, done timing.
    nums[4] = 16'h1234;
    nums[5] = 16'hBEEF;
    clear_q();
    s0 = start_cnt;
    d0 = done_cnt;
    g0 = grant_cnt;
    req = 4'b0100;
    c0 = cyc;
    wait_grant("t1", 4'b0100, g);
    check("t1_busy_grant", sched_busy, 1);
    req = 4'b0;
    wait_done("t1", d0);
    check("t1_busy_done", sched_busy, 1);
    check("t1_done_lat", done_cyc - fall_cyc, 1);
    tick();
    check("t1_busy_after", sched_busy, 0);
    check("t1_done_pulse", done, 0);
    check_bytes("t1", 8'hA2, 8'h34, 8'h12, 8'hEF, 8'hBE);
    check("t1_starts", start_cnt - s0, 5);
    check("t1_grants", grant_cnt - g0, 1);
    check("t1_latency", (start_q.size() > 0) ? start_q[0] - c0 : -1, 2);

    // All requesters held: round-robin order from pointer 0.
    do_reset();
    hold = 4;
    for (int i = 0; i < 8; i++) nums[i] = 16'(i * 32'h0123 + 32'h4001);
    req = 4'hF;
    for (int p = 0; p < 5; p++) begin
      string t;
      t = $sformatf("t2_p%0d", p);
      clear_q();
      d0 = done_cnt;
      wait_grant(t, 4'b0001 << (p % 4), g);
      if (p == 4) req = 4'b0;
      wait_done(t, d0);
      check_pkt(t, p % 4);
    end
    check("t2_onehot", multi_err, 0);

    // Pointer wrap behaviour.
    do_reset();
    hold = 3;
    run_pkt("t3a", 4'b0100, 2);
    run_pkt("t3b", 4'b0101, 0);
    run_pkt("t3c", 4'b0100, 2);
    run_pkt("t3d", 4'b1001, 3);
    run_pkt("t3e", 4'b0101, 0);

    // Serializer stuck busy after the second byte.
    hold = 10;
    clear_q();
    s0 = start_cnt;
    d0 = done_cnt;
    req = 4'b1000;
    wait_grant("t4", 4'b1000, g);
    req = 4'b0;
    n = 0;
    while (start_cnt < s0 + 2 && n < 500) begin
      tick();
      n++;
    end
    busy_force = 1'b1;
    repeat (50) tick();
    check("t4_no_start", start_cnt - s0, 2);
    busy_force = 1'b0;
    rel = cyc;
    n = 0;
    while (start_cnt < s0 + 3 && n < 100) begin
      tick();
      n++;
    end
    check("t4_resume", (start_q.size() > 0) ? start_q[$] - rel : -1, 2);
    wait_done("t4", d0);
    check_pkt("t4", 3);

    // Sign-bit payloads pass through unchanged.
    nums[2] = 16'h8000;
    nums[3] = 16'hFFFF;
    run_pkt("t5", 4'b0010, 1);
    check_bytes("t5c", 8'hA1, 8'h00, 8'h80, 8'hFF, 8'hFF);

    // Reset in the middle of a packet.
    hold = 10;
    clear_q();
    s0 = start_cnt;
    req = 4'b0100;
    wait_grant("t6a", 4'b0100, g);
    req = 4'b0;
    n = 0;
    while (start_cnt < s0 + 3 && n < 500) begin
      tick();
      n++;
    end
    tick();
    tick();
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    check("t6_start", tx_start, 0);
    check("t6_busy", sched_busy, 0);
    check("t6_done", done, 0);
    check("t6_byte", tx_byte, 0);
    repeat (3) tick();
    check("t6_no_done", done_cnt - d0, 0);
    req = 4'b1010;
    reset = 1'b1;
    clear_q();
    d0 = done_cnt;
    wait_grant("t6b", 4'b0010, g);
    req = 4'b0;
    wait_done("t6b", d0);
    check_pkt("t6b", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
